// File: rtl/rv32_fetch.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order word reads to imem and
// buffers returned words with their PCs in a small FIFO feeding the decoder.
module rv32_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        fetch_trap
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_RUN, S_HALT, S_TRAP} state_t;

  state_t        state, state_nx;
  logic [31:0]   fetch_pc, rsp_pc;
  logic [CW-1:0] count, outstanding, outstanding_nx, drop_cnt;
  logic [CW:0]   credit_used;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   fifo_instr [FIFO_DEPTH];
  logic [31:0]   fifo_pc    [FIFO_DEPTH];
  logic          misaligned, req_fire, drop, push, pop;

  assign misaligned = redirect_pc[1:0] != 2'b00;

  always_comb begin
    state_nx = state;
    case (state)
      S_RUN:   if (halt) state_nx = S_HALT;
      S_HALT:  if (!halt) state_nx = S_RUN;
      S_TRAP:  if (redirect_valid) state_nx = S_RUN;
      default: state_nx = S_RUN;
    endcase
    if (redirect_valid && misaligned) state_nx = S_TRAP;
  end

  // Credits cover both buffered words and words still in flight, so a push never overflows.
  assign credit_used    = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = !rst && (state == S_RUN) && !redirect_valid
                          && (credit_used < {1'b0, DEPTH_C});
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response arriving in the redirect cycle belongs to the old stream and is discarded too.
  assign drop           = imem_rsp_valid && (redirect_valid || drop_cnt != '0);
  assign push           = imem_rsp_valid && !drop;
  assign pop            = instr_valid && instr_ready && !redirect_valid;
  assign outstanding_nx = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

  assign instr_valid = count != '0;
  assign instr       = fifo_instr[rd_ptr];
  assign pc          = fifo_pc[rd_ptr];
  assign fetch_trap  = state == S_TRAP;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RUN;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr[i] <= NOP;
        fifo_pc[i]    <= RESET_PC;
      end
    end else begin
      state       <= state_nx;
      outstanding <= outstanding_nx;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        rsp_pc   <= redirect_pc;
        drop_cnt <= outstanding_nx;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
        if (push) begin
          fifo_instr[wr_ptr] <= imem_rsp_data;
          fifo_pc[wr_ptr]    <= rsp_pc;
          wr_ptr             <= wr_ptr + PW'(1);
          rsp_pc             <= rsp_pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_rv32_fetch.sv
// Self-checking bench for rv32_fetch: an epoch-tagged imem/stream model predicts every
// request and every delivered {pc, instr}, compared each cycle under directed and random stimulus.
module tb_rv32_fetch;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          FIFO_DEPTH = 2;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        halt = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        fetch_trap;

  rv32_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .pc(pc),
    .fetch_trap(fetch_trap)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  req_t        mq[$];     // requests accepted by imem, oldest first
  ent_t        exp_q[$];  // words the decoder should still see, oldest first
  logic [31:0] m_next;
  logic        m_trap, m_halted, prev_halt;
  int          m_epoch, cyc, last_due, delivered, acc_in_halt;
  int          lat_min = 1, lat_max = 1;
  logic        rdy_rand = 1'b0;
  int          checks = 0, errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // One clock cycle; entered and left just after the falling edge.
  task automatic step();
    logic acc, rsp, pop, exp_rv;
    int   lat, due;
    req_t r;
    ent_t e;
    imem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    rsp = (mq.size() > 0) && (mq[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(mq[0].addr) : 32'hDEAD_BEEF;
    #1;
    chk("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("pc", pc, exp_q[0].pc);
      chk("instr", instr, exp_q[0].instr);
    end
    chk("fetch_trap", 32'(fetch_trap), 32'(m_trap));
    exp_rv = !m_trap && !m_halted && !redirect_valid && (exp_q.size() + mq.size() < FIFO_DEPTH);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (imem_req_valid) chk("req_addr", imem_req_addr, m_next);
    acc = imem_req_valid && imem_req_ready;
    pop = instr_valid && instr_ready && !redirect_valid;
    if (acc && prev_halt) acc_in_halt++;
    @(posedge clk);
    if (pop && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      delivered++;
    end
    if (rsp) begin
      r = mq.pop_front();
      if (r.epoch == m_epoch && !redirect_valid)
        exp_q.push_back('{pc: r.addr, instr: mem_word(r.addr)});
    end
    if (redirect_valid) begin
      m_epoch++;
      exp_q.delete();
      m_next = redirect_pc;
    end
    if (redirect_valid && redirect_pc[1:0] != 2'b00) m_trap = 1'b1;
    else if (m_trap) begin
      if (redirect_valid) begin
        m_trap   = 1'b0;
        m_halted = 1'b0;
      end
    end else m_halted = halt;
    if (acc) begin
      lat = $urandom_range(lat_min, lat_max);
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      last_due = due;
      mq.push_back('{addr: m_next, epoch: m_epoch, due: due});
      m_next = m_next + 32'd4;
    end
    prev_halt = halt;
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_req_ready = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    mq.delete(); exp_q.delete();
    m_next = RESET_PC; m_trap = 1'b0; m_halted = 1'b0; prev_halt = 1'b0;
    m_epoch = 0; last_due = 0;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_fetch_trap", 32'(fetch_trap), 32'd0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_instr", instr, NOP);
    rst = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int max_cyc);
    int n = 0;
    while (!instr_valid && n < max_cyc) begin
      step();
      n++;
    end
    chk(tag, 32'(instr_valid), 32'd1);
  endtask

  initial begin
    cyc = 0; delivered = 0; acc_in_halt = 0;
    @(negedge clk);
    do_reset();

    // Streaming from reset, 1-cycle memory
    instr_ready = 1'b1;
    repeat (30) step();
    chk("t1_throughput", 32'(delivered >= 15), 32'd1);

    // Decoder back-pressure fills the FIFO then stalls issue
    instr_ready = 1'b0;
    repeat (10) step();
    chk("t2_stall_req", 32'(imem_req_valid), 32'd0);
    chk("t2_full", 32'(instr_valid), 32'd1);
    instr_ready = 1'b1;
    repeat (20) step();

    // Redirect with two reads in flight
    lat_min = 3; lat_max = 3; instr_ready = 1'b0;
    do_redirect(32'h0000_0040);
    for (int i = 0; i < 10 && mq.size() != 2; i++) step();
    chk("t3_two_inflight", 32'(mq.size()), 32'd2);
    do_redirect(32'h0000_0100);
    wait_valid("t3_wait_first", 20);
    chk("t3_first_pc", pc, 32'h0000_0100);
    chk("t3_first_instr", instr, mem_word(32'h0000_0100));
    instr_ready = 1'b1; step(); instr_ready = 1'b0;
    wait_valid("t3_wait_second", 20);
    chk("t3_second_pc", pc, 32'h0000_0104);

    // Misaligned redirect traps until an aligned one
    lat_min = 1; lat_max = 2;
    do_redirect(32'h0000_0102);
    chk("t4_trap", 32'(fetch_trap), 32'd1);
    chk("t4_no_req", 32'(imem_req_valid), 32'd0);
    repeat (5) step();
    do_redirect(32'h0000_0200);
    chk("t4_trap_clear", 32'(fetch_trap), 32'd0);
    wait_valid("t4_wait", 20);
    chk("t4_pc", pc, 32'h0000_0200);

    // Halt mid-stream with random imem ready
    rdy_rand = 1'b1; lat_min = 1; lat_max = 3; instr_ready = 1'b1;
    repeat (10) step();
    halt = 1'b1; acc_in_halt = 0;
    repeat (5) step();
    halt = 1'b0;
    step();
    chk("t5_no_accept_in_halt", 32'(acc_in_halt), 32'd0);
    repeat (20) step();

    // PC wrap at top of address space
    rdy_rand = 1'b0; instr_ready = 1'b0;
    do_redirect(32'hFFFF_FFFC);
    wait_valid("t6_wait_top", 20);
    chk("t6_top_pc", pc, 32'hFFFF_FFFC);
    instr_ready = 1'b1; step(); instr_ready = 1'b0;
    wait_valid("t6_wait_wrap", 20);
    chk("t6_wrap_pc", pc, 32'h0000_0000);

    // Random mix of everything
    rdy_rand = 1'b1; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 500; i++) begin
      instr_ready = 1'($urandom_range(0, 3) != 0);
      halt        = 1'($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 29) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 3) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
      end
      step();
      redirect_valid = 1'b0;
    end
    halt = 1'b0;
    do_redirect(32'h0000_0300);
    instr_ready = 1'b1;
    repeat (20) step();
    chk("rand_delivered", 32'(delivered > 100), 32'd1);

    // Reset in the middle of traffic
    do_reset();
    instr_ready = 1'b1; rdy_rand = 1'b0;
    repeat (15) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
